// File: rtl/fsm_channel_scheduler_pkg.sv
// fsm_sched_pkg: state encoding and next-state function of the "101" detector,
// shared by the channel scheduler and the standalone detector.
package fsm_sched_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_A = 2'd0;
    localparam state_t ST_B = 2'd1;
    localparam state_t ST_C = 2'd2;
    localparam state_t ST_D = 2'd3;

    // B and D share successors: a 1 restarts the match at B, a 0 advances to C
    function automatic state_t fsm_next(input state_t s, input logic b);
        return (s == ST_A) ? (b ? ST_B : ST_A) :
               (s == ST_C) ? (b ? ST_D : ST_A) :
                             (b ? ST_B : ST_C);
    endfunction

endpackage

// File: rtl/fsm_channel_scheduler_if.sv
// fsm_channel_scheduler_if: per-channel bit handshake and the shared result record.
interface fsm_channel_scheduler_if #(
    parameter int NUM_CH = 4,
    localparam int CH_W = $clog2(NUM_CH)
);

    logic [NUM_CH-1:0] in_valid;
    logic [NUM_CH-1:0] in_bit;
    logic [NUM_CH-1:0] in_ready;
    logic [NUM_CH-1:0] clr;
    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic [1:0]        out_state;
    logic              out_detect;

    modport master (
        output in_valid, in_bit, clr,
        input  in_ready, out_valid, out_ch, out_state, out_detect
    );

    modport slave (
        input  in_valid, in_bit, clr,
        output in_ready, out_valid, out_ch, out_state, out_detect
    );

endinterface

// File: rtl/fsm_channel_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, scanning req upward from ptr with wrap.
module rr_arbiter #(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);

    logic [W-1:0] idx;
    logic         found;

    always_comb begin
        gnt = '0;
        gnt_idx = '0;
        idx = '0;
        found = 1'b0;
        for (int o = 0; o < N; o++) begin
            idx = W'((int'(ptr) + o) % N);
            if (!found && req[idx]) begin
                found = 1'b1;
                gnt_idx = idx;
            end
        end
        gnt[gnt_idx] = found;
    end

endmodule

// File: rtl/fsm_channel_scheduler.sv
// fsm_channel_scheduler: time-shares one "101" detector next-state datapath across
// NUM_CH bit streams, one round-robin grant per cycle, one result record per step.
module fsm_channel_scheduler
    import fsm_sched_pkg::*;
#(
    parameter int NUM_CH = 4,
    localparam int CH_W = $clog2(NUM_CH)
) (
    input logic clk,
    input logic areset,
    fsm_channel_scheduler_if.slave bus
);

    state_t [NUM_CH-1:0] st_q, st_d;
    logic   [NUM_CH-1:0] pend_q, pend_d;
    logic   [NUM_CH-1:0] buf_q, buf_d;
    logic   [NUM_CH-1:0] req, gnt, ready, acc;
    logic   [CH_W-1:0]   rr_ptr_q, rr_ptr_d, gnt_idx;
    logic   [CH_W-1:0]   out_ch_q, out_ch_d;
    state_t              out_state_q, out_state_d, nxt;
    logic                out_valid_q, out_valid_d;
    logic                out_detect_q, out_detect_d;
    logic                any_gnt;

    // a channel being cleared this cycle must not consume the shared step
    assign req     = pend_q & ~bus.clr;
    assign ready   = ~pend_q | gnt;
    assign acc     = bus.in_valid & ready;
    assign any_gnt = |gnt;
    assign nxt     = fsm_next(st_q[gnt_idx], buf_q[gnt_idx]);

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .req     (req),
        .ptr     (rr_ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    always_comb begin
        st_d = st_q;
        pend_d = pend_q;
        buf_d = buf_q;
        for (int i = 0; i < NUM_CH; i++) begin
            pend_d[i] = bus.clr[i] ? 1'b0 : (acc[i] | (pend_q[i] & ~gnt[i]));
            buf_d[i] = acc[i] ? bus.in_bit[i] : buf_q[i];
            st_d[i] = bus.clr[i] ? ST_A : (gnt[i] ? nxt : st_q[i]);
        end
        rr_ptr_d = any_gnt ? ((gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1) : rr_ptr_q;
        out_valid_d = any_gnt;
        out_ch_d = any_gnt ? gnt_idx : out_ch_q;
        out_state_d = any_gnt ? nxt : out_state_q;
        out_detect_d = any_gnt ? (nxt == ST_D) : out_detect_q;
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            st_q <= {NUM_CH{ST_A}};
            pend_q <= '0;
            buf_q <= '0;
            rr_ptr_q <= '0;
            out_valid_q <= 1'b0;
            out_ch_q <= '0;
            out_state_q <= ST_A;
            out_detect_q <= 1'b0;
        end else begin
            st_q <= st_d;
            pend_q <= pend_d;
            buf_q <= buf_d;
            rr_ptr_q <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_ch_q <= out_ch_d;
            out_state_q <= out_state_d;
            out_detect_q <= out_detect_d;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_ch     = out_ch_q;
    assign bus.out_state  = out_state_q;
    assign bus.out_detect = out_detect_q;

endmodule

// File: tb/tb_fsm_channel_scheduler.sv
// tb_fsm_channel_scheduler: directed stimulus with per-channel expected-record queues
// filled at accept time and drained as records appear.
module tb_fsm_channel_scheduler;

    localparam int NCH = 4;

    typedef struct packed {
        logic [1:0] st;
        logic       det;
    } rec_t;

    logic        clk = 1'b0;
    logic        areset;
    int          checks = 0;
    int          errors = 0;
    rec_t        exp_q [NCH][$];
    logic [1:0]  mst [NCH];
    int          last_st [NCH];
    int          last_det [NCH];
    logic [15:0] t2_ready = 16'hFF73;
    logic [2:0]  seq1 = 3'b101;

    fsm_channel_scheduler_if #(.NUM_CH(NCH)) bus ();

    fsm_channel_scheduler #(.NUM_CH(NCH)) dut (
        .clk    (clk),
        .areset (areset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] ref_next(input logic [1:0] s, input logic b);
        case (s)
            2'd0:    return b ? 2'd1 : 2'd0;
            2'd1:    return b ? 2'd1 : 2'd2;
            2'd2:    return b ? 2'd3 : 2'd0;
            default: return b ? 2'd1 : 2'd2;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: score the record from the last edge, model accepts for the next edge
    task automatic tick();
        rec_t r;
        int   c;
        @(negedge clk);
        if (bus.out_valid === 1'b1) begin
            c = int'(bus.out_ch);
            last_st[c] = int'(bus.out_state);
            last_det[c] = int'(bus.out_detect);
            checks++;
            assert (exp_q[c].size() != 0) else begin
                errors++;
                $error("FAIL rec_unexpected ch%0d: observed state %0d expected no record", c, bus.out_state);
            end
            if (exp_q[c].size() != 0) begin
                r = exp_q[c].pop_front();
                chk("rec_state", 32'(bus.out_state), 32'(r.st));
                chk("rec_detect", 32'(bus.out_detect), 32'(r.det));
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (bus.clr[i]) begin
                mst[i] = 2'd0;
                exp_q[i].delete();
            end else if (bus.in_valid[i] && bus.in_ready[i]) begin
                mst[i] = ref_next(mst[i], bus.in_bit[i]);
                r.st = mst[i];
                r.det = (mst[i] == 2'd3);
                exp_q[i].push_back(r);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // called at posedge+1; asserts reset mid-cycle and holds it across one edge
    task automatic do_reset();
        #2 areset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_ch", 32'(bus.out_ch), 32'd0);
        chk("rst_out_state", 32'(bus.out_state), 32'd0);
        chk("rst_out_detect", 32'(bus.out_detect), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'hF);
        bus.in_valid = '0;
        bus.clr = '0;
        for (int i = 0; i < NCH; i++) begin
            mst[i] = 2'd0;
            exp_q[i].delete();
            last_st[i] = -1;
            last_det[i] = -1;
        end
        @(posedge clk);
        #2 areset = 1'b0;
        tick();
    endtask

    initial begin
        areset = 1'b1;
        bus.in_valid = '0;
        bus.in_bit = '0;
        bus.clr = '0;
        for (int i = 0; i < NCH; i++) begin
            mst[i] = 2'd0;
            last_st[i] = -1;
            last_det[i] = -1;
        end
        @(posedge clk);
        #1;
        chk("init_out_valid", 32'(bus.out_valid), 32'd0);
        chk("init_out_ch", 32'(bus.out_ch), 32'd0);
        chk("init_out_state", 32'(bus.out_state), 32'd0);
        chk("init_out_detect", 32'(bus.out_detect), 32'd0);
        chk("init_in_ready", 32'(bus.in_ready), 32'hF);
        #2 areset = 1'b0;
        tick();

        // 1: ch0 alone, 1,0,1 back-to-back
        bus.in_valid = 4'b0001;
        bus.in_bit = 4'b0001;
        tick();
        chk("t1_latency", 32'(bus.out_valid), 32'd0);
        bus.in_bit = 4'b0000;
        tick();
        chk("t1_r1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_r1_ch", 32'(bus.out_ch), 32'd0);
        chk("t1_r1_state", 32'(bus.out_state), 32'd1);
        chk("t1_r1_det", 32'(bus.out_detect), 32'd0);
        bus.in_bit = 4'b0001;
        tick();
        chk("t1_r2_state", 32'(bus.out_state), 32'd2);
        chk("t1_r2_det", 32'(bus.out_detect), 32'd0);
        bus.in_valid = '0;
        tick();
        chk("t1_r3_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_r3_state", 32'(bus.out_state), 32'd3);
        chk("t1_r3_det", 32'(bus.out_detect), 32'd1);
        tick();
        chk("t1_idle_valid", 32'(bus.out_valid), 32'd0);
        chk("t1_idle_hold", 32'(bus.out_state), 32'd3);

        // 2: all channels offer together after reset
        do_reset();
        bus.in_valid = 4'b1111;
        bus.in_bit = 4'b1101;
        chk("t2_ready_pre", 32'(bus.in_ready), 32'hF);
        tick();
        bus.in_valid = '0;
        chk("t2_ready_0", 32'(bus.in_ready), 32'h1);
        chk("t2_no_rec", 32'(bus.out_valid), 32'd0);
        for (int k = 0; k < NCH; k++) begin
            tick();
            chk("t2_valid", 32'(bus.out_valid), 32'd1);
            chk("t2_order", 32'(bus.out_ch), 32'(k));
            chk("t2_ready", 32'(bus.in_ready), 32'(t2_ready[k*4 +: 4]));
        end
        tick();
        chk("t2_idle", 32'(bus.out_valid), 32'd0);

        // 3: ch0 and ch2 continuously valid
        bus.in_valid = 4'b0101;
        for (int k = 0; k < 8; k++) begin
            bus.in_bit = 4'($urandom) & 4'b0101;
            tick();
            if (k >= 1) begin
                chk("t3_valid", 32'(bus.out_valid), 32'd1);
                chk("t3_alt", 32'(bus.out_ch), (k % 2 == 1) ? 32'd0 : 32'd2);
            end
        end
        bus.in_valid = '0;
        tick();
        chk("t3_drain_a", 32'(bus.out_ch), 32'd2);
        tick();
        chk("t3_drain_b", 32'(bus.out_ch), 32'd0);
        tick();
        chk("t3_idle", 32'(bus.out_valid), 32'd0);

        // 4: ch1 gets 1,0,1 interleaved with ch3 getting 0,0,0
        do_reset();
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = (i % 2 == 0) ? 4'b0010 : 4'b1000;
            bus.in_bit = {2'b00, seq1[2 - i/2], 1'b0};
            tick();
        end
        bus.in_valid = '0;
        tick();
        tick();
        tick();
        chk("t4_ch1_state", 32'(last_st[1]), 32'd3);
        chk("t4_ch1_det", 32'(last_det[1]), 32'd1);
        chk("t4_ch3_state", 32'(last_st[3]), 32'd0);
        chk("t4_ch3_det", 32'(last_det[3]), 32'd0);

        // 5: ch2 to C, then clear while offering a 1
        bus.in_valid = 4'b0100;
        bus.in_bit = 4'b0100;
        tick();
        bus.in_valid = '0;
        tick();
        bus.in_valid = 4'b0100;
        bus.in_bit = 4'b0000;
        tick();
        bus.in_valid = '0;
        tick();
        chk("t5_at_c", 32'(bus.out_state), 32'd2);
        tick();
        bus.clr = 4'b0100;
        bus.in_valid = 4'b0100;
        bus.in_bit = 4'b0100;
        chk("t5_ready_clr", 32'(bus.in_ready), 32'hF);
        tick();
        chk("t5_no_rec", 32'(bus.out_valid), 32'd0);
        bus.clr = '0;
        bus.in_valid = '0;
        tick();
        chk("t5_no_rec2", 32'(bus.out_valid), 32'd0);
        bus.in_valid = 4'b0100;
        bus.in_bit = 4'b0100;
        tick();
        bus.in_valid = '0;
        tick();
        chk("t5_after_ch", 32'(bus.out_ch), 32'd2);
        chk("t5_after_state", 32'(bus.out_state), 32'd1);
        chk("t5_after_det", 32'(bus.out_detect), 32'd0);
        tick();

        // 6: reset while records are flowing
        bus.in_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            bus.in_bit = 4'($urandom);
            tick();
        end
        chk("t6_flowing", 32'(bus.out_valid), 32'd1);
        do_reset();
        bus.in_valid = 4'b1111;
        bus.in_bit = 4'b1111;
        tick();
        bus.in_valid = '0;
        for (int k = 0; k < NCH; k++) begin
            tick();
            chk("t6_valid", 32'(bus.out_valid), 32'd1);
            chk("t6_order", 32'(bus.out_ch), 32'(k));
            chk("t6_from_a", 32'(bus.out_state), 32'd1);
        end
        tick();
        chk("t6_idle", 32'(bus.out_valid), 32'd0);

        for (int i = 0; i < NCH; i++)
            chk("queue_empty", 32'(exp_q[i].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
